// File: rtl/givens_cordic_unit.sv
// Iterative CORDIC Givens cell: vectoring (boundary) or rotation (internal) role,
// UNFOLD saturating micro-rotations per clock, gain-corrected, valid/ready on both sides.
module givens_cordic_unit #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC_WIDTH = 10,
  parameter int ITER       = 12,
  parameter int UNFOLD     = 4,
  parameter int K          = 621
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] y_i,
  input  logic        [ITER-1:0]       d_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] x_o,
  output logic signed [DATA_WIDTH-1:0] y_o,
  output logic        [ITER-1:0]       d_o
);
  localparam int DW    = DATA_WIDTH;
  localparam int STEPS = ITER / UNFOLD;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STEPS - 1);
  localparam logic signed [DW-1:0] MAX_V    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_V    = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [DW-1:0]   x_q, x_d, y_q, y_d;
  logic                   mode_q, mode_d;
  logic [ITER-1:0]        d_q, d_d;
  logic signed [DW-1:0]   x_o_q, x_o_d, y_o_q, y_o_d;
  logic [ITER-1:0]        d_o_q, d_o_d;
  logic                   accept;

  function automatic logic signed [DW-1:0] sat_sum(input logic signed [DW:0] s);
    if (s[DW] != s[DW-1]) return s[DW] ? MIN_V : MAX_V;
    return s[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] v);
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] shr;
    prod = (2*DW)'(v) * (2*DW)'(K);
    shr  = prod >>> FRAC_WIDTH;
    if ((&shr[2*DW-1:DW-1]) || !(|shr[2*DW-1:DW-1])) return shr[DW-1:0];
    return shr[2*DW-1] ? MIN_V : MAX_V;
  endfunction

  // Unrolled chain of micro-rotations; stage gi handles iteration cnt*UNFOLD+gi.
  logic signed [DW-1:0]            xs [UNFOLD+1];
  logic signed [DW-1:0]            ys [UNFOLD+1];
  logic [UNFOLD-1:0]               ds;
  logic [UNFOLD-1:0][IDX_W-1:0]    ns;

  assign xs[0] = x_q;
  assign ys[0] = y_q;

  for (genvar gi = 0; gi < UNFOLD; gi++) begin : g_stage
    logic signed [DW-1:0] xsh, ysh;
    logic signed [DW:0]   xsum, ysum;
    assign ns[gi]  = IDX_W'(cnt_q) * IDX_W'(UNFOLD) + IDX_W'(gi);
    assign ds[gi]  = mode_q ? d_q[ns[gi]] : (~xs[gi][DW-1] ^ ys[gi][DW-1]);
    assign xsh     = xs[gi] >>> ns[gi];
    assign ysh     = ys[gi] >>> ns[gi];
    assign xsum    = ds[gi] ? ({xs[gi][DW-1], xs[gi]} + {ysh[DW-1], ysh})
                            : ({xs[gi][DW-1], xs[gi]} - {ysh[DW-1], ysh});
    assign ysum    = ds[gi] ? ({ys[gi][DW-1], ys[gi]} - {xsh[DW-1], xsh})
                            : ({ys[gi][DW-1], ys[gi]} + {xsh[DW-1], xsh});
    assign xs[gi+1] = sat_sum(xsum);
    assign ys[gi+1] = sat_sum(ysum);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    mode_d    = mode_q;
    d_d       = d_q;
    x_o_d     = x_o_q;
    y_o_d     = y_o_q;
    d_o_d     = d_o_q;
    in_ready  = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
    out_valid = (state_q == S_OUT);
    accept    = in_ready && in_valid;

    case (state_q)
      S_ITER: begin
        x_d = xs[UNFOLD];
        y_d = ys[UNFOLD];
        for (int i = 0; i < UNFOLD; i++) d_d[ns[i]] = ds[i];
        if (cnt_q == CNT_LAST) state_d = S_SCALE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_SCALE: begin
        x_o_d   = scale(x_q);
        y_o_d   = scale(y_q);
        d_o_d   = d_q;
        state_d = S_OUT;
      end
      S_OUT: if (out_ready) state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      x_d     = x_i;
      y_d     = y_i;
      mode_d  = mode_i;
      d_d     = mode_i ? d_i : '0;
      cnt_d   = '0;
      state_d = S_ITER;
    end

    // Abort wins over any handshake in the same cycle, including a pending operand.
    if (clr_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      x_d     = x_q;
      y_d     = y_q;
      mode_d  = mode_q;
      d_d     = d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
      d_q     <= '0;
      x_o_q   <= '0;
      y_o_q   <= '0;
      d_o_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      x_o_q   <= x_o_d;
      y_o_q   <= y_o_d;
      d_o_q   <= d_o_d;
    end
  end

  assign x_o = x_o_q;
  assign y_o = y_o_q;
  assign d_o = d_o_q;

endmodule
